// File: rtl/dff.sv
// Purpose: single D flip-flop cell of parameterised width; every arbiter flop is one of these.
// Latency: one clock; output follows input on the next rising edge.
// Backpressure: none; captures unconditionally, synchronous active-high reset loads RST_VAL.
module dff #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Capture the next value each edge; reset wins over data
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RST_VAL;
        end else begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Purpose: two-requester (I/D cache) ownership arbiter for a shared four-bank memory.
// Latency: grant one cycle after request is sampled in IDLE; read return RD_LAT cycles after accept.
// Backpressure: x_stall holds non-owners and the owner while mem_stall is high; stalled reads are not tracked.
module mem_arbiter #(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic        i_rd,
    input  logic        i_wr,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_data_in,
    output logic        i_grant,
    output logic        i_stall,
    output logic [15:0] i_data_out,
    output logic        i_data_valid,
    input  logic        d_req,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_data_in,
    output logic        d_grant,
    output logic        d_stall,
    output logic [15:0] d_data_out,
    output logic        d_data_valid,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [15:0] mem_data_out,
    input  logic        mem_stall,
    output logic        err
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_OWN_I   = 2'd1;
    localparam logic [1:0] ST_OWN_D   = 2'd2;
    localparam logic       OWNER_I    = 1'b0;
    localparam logic       OWNER_D    = 1'b1;
    localparam logic [4:0] HOLD_MAX   = 5'd31;
    localparam logic [4:0] HOLD_LIMIT = 5'(TIMEOUT - 1);

    logic [1:0] r_state, w_state_nxt;
    logic       r_last_owner, w_last_owner_nxt;
    logic [4:0] r_hold_cnt, w_hold_cnt_nxt;
    logic       r_err, w_err_nxt;
    logic       r_i_grant, r_d_grant;
    logic       w_own_i, w_own_d, w_proto_err, w_timeout;
    logic [1:0] r_ret [RD_LAT];
    logic [1:0] w_ret_d [RD_LAT];

    assign w_own_i = (r_state == ST_OWN_I);
    assign w_own_d = (r_state == ST_OWN_D);

    // Ownership FSM next state: on conflict from IDLE the previous owner yields; hand-over skips IDLE
    always_comb begin
        w_state_nxt = ST_IDLE;
        case (r_state)
            ST_IDLE: begin
                if (i_req && d_req) begin
                    w_state_nxt = (r_last_owner == OWNER_I) ? ST_OWN_D : ST_OWN_I;
                end else if (i_req) begin
                    w_state_nxt = ST_OWN_I;
                end else if (d_req) begin
                    w_state_nxt = ST_OWN_D;
                end
            end
            ST_OWN_I: w_state_nxt = i_req ? ST_OWN_I : (d_req ? ST_OWN_D : ST_IDLE);
            ST_OWN_D: w_state_nxt = d_req ? ST_OWN_D : (i_req ? ST_OWN_I : ST_IDLE);
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Remember who left an OWN state last, for the IDLE tie-break
    always_comb begin
        w_last_owner_nxt = r_last_owner;
        if (w_own_i && (w_state_nxt != ST_OWN_I)) begin
            w_last_owner_nxt = OWNER_I;
        end else if (w_own_d && (w_state_nxt != ST_OWN_D)) begin
            w_last_owner_nxt = OWNER_D;
        end
    end

    // Memory-side mux from the owner; a simultaneous rd+wr is dropped and flagged
    always_comb begin
        mem_addr    = 16'h0000;
        mem_data_in = 16'h0000;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        w_proto_err = 1'b0;
        if (w_own_i) begin
            mem_addr    = i_addr;
            mem_data_in = i_data_in;
            mem_rd      = i_rd & ~i_wr;
            mem_wr      = i_wr & ~i_rd;
            w_proto_err = i_rd & i_wr;
        end else if (w_own_d) begin
            mem_addr    = d_addr;
            mem_data_in = d_data_in;
            mem_rd      = d_rd & ~d_wr;
            mem_wr      = d_wr & ~d_rd;
            w_proto_err = d_rd & d_wr;
        end
    end

    // Hold counter: zero on entering an OWN state (or in IDLE), saturating count while ownership is kept
    always_comb begin
        w_hold_cnt_nxt = r_hold_cnt;
        if ((w_state_nxt == ST_IDLE) || (w_state_nxt != r_state)) begin
            w_hold_cnt_nxt = 5'd0;
        end else if (r_hold_cnt != HOLD_MAX) begin
            w_hold_cnt_nxt = r_hold_cnt + 5'd1;
        end
        // Staying in OWN_x implies x_req is still high, so the owner is still asking when the limit hits
        w_timeout = (r_state != ST_IDLE) && (w_state_nxt == r_state) && (w_hold_cnt_nxt == HOLD_LIMIT);
        w_err_nxt = r_err | w_proto_err | w_timeout;
    end

    // Read-return tracker input: push {valid, owner} only for reads the memory accepted
    always_comb begin
        w_ret_d[0] = {mem_rd & ~mem_stall, w_own_d ? OWNER_D : OWNER_I};
        for (int k = 1; k < RD_LAT; k++) begin
            w_ret_d[k] = r_ret[k-1];
        end
    end

    dff #(.W(2), .RST_VAL(ST_IDLE)) u_state      (.clk(clk), .rst(rst), .i_d(w_state_nxt),            .o_q(r_state));
    dff #(.W(1), .RST_VAL(OWNER_I)) u_last_owner (.clk(clk), .rst(rst), .i_d(w_last_owner_nxt),       .o_q(r_last_owner));
    dff #(.W(5))                    u_hold_cnt   (.clk(clk), .rst(rst), .i_d(w_hold_cnt_nxt),         .o_q(r_hold_cnt));
    dff #(.W(1))                    u_err        (.clk(clk), .rst(rst), .i_d(w_err_nxt),              .o_q(r_err));
    dff #(.W(1))                    u_i_grant    (.clk(clk), .rst(rst), .i_d(w_state_nxt == ST_OWN_I), .o_q(r_i_grant));
    dff #(.W(1))                    u_d_grant    (.clk(clk), .rst(rst), .i_d(w_state_nxt == ST_OWN_D), .o_q(r_d_grant));

    for (genvar g = 0; g < RD_LAT; g++) begin : g_ret
        dff #(.W(2)) u_ret (.clk(clk), .rst(rst), .i_d(w_ret_d[g]), .o_q(r_ret[g]));
    end

    assign i_grant      = r_i_grant;
    assign d_grant      = r_d_grant;
    assign err          = r_err;
    assign i_stall      = i_req & (~w_own_i | mem_stall);
    assign d_stall      = d_req & (~w_own_d | mem_stall);
    assign i_data_out   = mem_data_out;
    assign d_data_out   = mem_data_out;
    assign i_data_valid = r_ret[RD_LAT-1][1] & (r_ret[RD_LAT-1][0] == OWNER_I);
    assign d_data_valid = r_ret[RD_LAT-1][1] & (r_ret[RD_LAT-1][0] == OWNER_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: directed scoreboard bench for mem_arbiter with a RD_LAT=2 memory model.
// Latency: expects grant one cycle after request, read data two cycles after an accepted read.
// Backpressure: drives mem_stall to hold the owner; returns are matched in order against a queue.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_rd, i_wr, d_req, d_rd, d_wr, mem_stall;
    logic [15:0] i_addr, i_data_in, d_addr, d_data_in;
    logic        i_grant, i_stall, i_data_valid, d_grant, d_stall, d_data_valid;
    logic [15:0] i_data_out, d_data_out, mem_addr, mem_data_in, mem_data_out;
    logic        mem_rd, mem_wr, err;

    typedef struct {
        logic        owner_d;
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] mp0 = 16'h0;
    logic [15:0] mp1 = 16'h0;

    mem_arbiter #(.RD_LAT(2), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_rd(i_rd), .i_wr(i_wr), .i_addr(i_addr), .i_data_in(i_data_in),
        .i_grant(i_grant), .i_stall(i_stall), .i_data_out(i_data_out), .i_data_valid(i_data_valid),
        .d_req(d_req), .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_data_in(d_data_in),
        .d_grant(d_grant), .d_stall(d_stall), .d_data_out(d_data_out), .d_data_valid(d_data_valid),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_data_out(mem_data_out), .mem_stall(mem_stall), .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory model: accepted read data appears on mem_data_out two cycles later
    always @(posedge clk) begin
        mp1 <= mp0;
        mp0 <= (mem_rd && !mem_stall) ? mdata(mem_addr) : 16'h0;
    end
    assign mem_data_out = mp1;

    task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Return monitor: every valid must match the oldest outstanding read
    always @(negedge clk) begin
        if (i_data_valid || d_data_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $error("FAIL ret_unexpected observed i_v=%0b d_v=%0b expected no return", i_data_valid, d_data_valid);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ret_dat", 48'({i_data_valid, d_data_valid, d_data_valid ? d_data_out : i_data_out}),
                               48'({!e.owner_d, e.owner_d, e.data}));
                chk("ret_lat", 48'(cyc), 48'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobes_off();
        i_rd = 1'b0; i_wr = 1'b0; d_rd = 1'b0; d_wr = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_stall = 1'b0;
        strobes_off();
        tick();
        rst = 1'b0;
    endtask

    task automatic d_read(input logic [15:0] a);
        d_rd = 1'b1; d_wr = 1'b0; d_addr = a;
        sb.push_back('{1'b1, mdata(a), cyc + 2});
    endtask

    task automatic i_read(input logic [15:0] a);
        i_rd = 1'b1; i_wr = 1'b0; i_addr = a;
        sb.push_back('{1'b0, mdata(a), cyc + 2});
    endtask

    initial begin
        logic [15:0] a;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; mem_stall = 1'b0;
        i_addr = 16'h0; i_data_in = 16'h0; d_addr = 16'h0; d_data_in = 16'h0;
        strobes_off();
        repeat (2) tick();
        @(negedge clk);
        chk("rst_outs", 48'({i_grant, d_grant, i_stall, d_stall, i_data_valid, d_data_valid,
                             mem_rd, mem_wr, err, mem_addr, mem_data_in}), 48'h0);
        tick();
        i_req = 1'b1;
        @(negedge clk);
        chk("rst_stall_eq_req", 48'({i_stall, d_stall, i_grant, d_grant}), 48'(4'b1000));
        tick();
        rst = 1'b0; i_req = 1'b0;

        // Solo D miss: 4 writes then 4 reads
        tick();
        d_req = 1'b1;
        @(negedge clk);
        chk("solo_d_c0", 48'({d_grant, d_stall}), 48'(2'b01));
        tick();
        @(negedge clk);
        chk("solo_d_grant", 48'({d_grant, d_stall, i_grant}), 48'(3'b100));
        for (int i = 0; i < 4; i++) begin
            tick();
            a = 16'h1230 + 16'(2 * i);
            d_wr = 1'b1; d_rd = 1'b0; d_addr = a; d_data_in = a ^ 16'h5555;
            @(negedge clk);
            chk("solo_d_wr", 48'({mem_wr, mem_rd, mem_addr, mem_data_in}), 48'({2'b10, a, a ^ 16'h5555}));
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            a = 16'h4A30 + 16'(2 * i);
            d_read(a);
            @(negedge clk);
            chk("solo_d_rd", 48'({mem_rd, mem_wr, mem_addr}), 48'({2'b10, a}));
        end
        tick();
        strobes_off();
        repeat (3) tick();
        d_req = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        chk("solo_d_release", 48'({d_grant, i_grant, mem_rd}), 48'(3'b000));

        // Conflict right after reset: D wins, then hands over to I with no IDLE gap
        do_reset();
        tick();
        i_req = 1'b1; d_req = 1'b1;
        @(negedge clk);
        chk("conf_c0", 48'({i_grant, d_grant, i_stall, d_stall}), 48'(4'b0011));
        tick();
        @(negedge clk);
        chk("conf_d_first", 48'({i_grant, d_grant, i_stall, d_stall}), 48'(4'b0110));
        for (int i = 0; i < 4; i++) begin
            tick();
            d_read(16'h2000 + 16'(2 * i));
            if (i == 3) d_req = 1'b0;
            @(negedge clk);
            chk("conf_i_stall", 48'({i_stall, i_grant, d_grant, mem_rd}), 48'(4'b1011));
        end
        tick();
        strobes_off();
        i_read(16'h0100);
        @(negedge clk);
        chk("handover", 48'({i_grant, d_grant, i_stall, mem_rd, mem_addr}), 48'({4'b1001, 16'h0100}));
        tick();
        strobes_off();
        repeat (3) tick();

        // Bank stall on an I read at 0x0008
        for (int i = 0; i < 3; i++) begin
            tick();
            i_rd = 1'b1; i_wr = 1'b0; i_addr = 16'h0008; mem_stall = 1'b1;
            @(negedge clk);
            chk("stall_hold", 48'({i_stall, mem_rd, d_stall}), 48'(3'b110));
        end
        tick();
        mem_stall = 1'b0;
        i_read(16'h0008);
        @(negedge clk);
        chk("stall_release", 48'({i_stall, mem_rd}), 48'(2'b01));
        tick();
        strobes_off();
        repeat (3) tick();
        @(negedge clk);
        chk("err_clean", 48'(err), 48'(1'b0));

        // Protocol error: rd+wr together from the owner
        tick();
        i_rd = 1'b1; i_wr = 1'b1; i_addr = 16'h0010;
        @(negedge clk);
        chk("proto_mask", 48'({mem_rd, mem_wr, err}), 48'(3'b000));
        tick();
        strobes_off();
        @(negedge clk);
        chk("proto_err", 48'(err), 48'(1'b1));
        tick();
        i_req = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", 48'({err, i_grant}), 48'(2'b10));
        do_reset();
        @(negedge clk);
        chk("err_clr", 48'(err), 48'(1'b0));

        // Timeout: D holds ownership; err at hold count 31, grant kept
        tick();
        d_req = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            @(negedge clk);
            if (k == 31) chk("tmo_pre", 48'({err, d_grant}), 48'(2'b01));
            if (k == 32) chk("tmo_err", 48'({err, d_grant}), 48'(2'b11));
        end
        chk("tmo_kept", 48'({err, d_grant, i_grant}), 48'(3'b110));

        // Mid-burst reset: two D reads in flight are dropped
        tick();
        d_rd = 1'b1; d_wr = 1'b0; d_addr = 16'h3000;
        tick();
        d_addr = 16'h3002; rst = 1'b1;
        tick();
        rst = 1'b0; d_req = 1'b0;
        strobes_off();
        @(negedge clk);
        chk("mbr_idle", 48'({i_grant, d_grant, i_data_valid, d_data_valid, mem_rd, err}), 48'h0);
        tick();
        @(negedge clk);
        chk("mbr_drop", 48'({d_data_valid, i_data_valid, d_grant, mem_rd}), 48'h0);
        repeat (3) tick();

        chk("sb_empty", 48'(sb.size()), 48'h0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter RD_LAT, default 2: memory read latency in cycles, from mem_rd accepted to mem_data_out valid.
REQ-002 Parameter TIMEOUT, default 32: maximum number of cycles one owner may hold the memory.
REQ-003 clk  in  1  single system clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 For each x in {i (instruction cache), d (data cache)}, the block SHALL have the following ports:
- x_req  in  1  ownership request; held for the whole miss burst.
- x_rd  in  1  read strobe.
- x_wr  in  1  write strobe.
- x_addr  in  16  word-aligned address.
- x_data_in  in  16  write data.
- x_grant  out  1  requester x owns memory this cycle.
- x_stall  out  1  requester x SHALL hold its request and strobes.
- x_data_out  out  16  read data; equals mem_data_out.
- x_data_valid  out  1  x_data_out holds the return of a read issued by x.
REQ-006 mem_addr  out  16  address to the four-bank memory.
REQ-007 mem_data_in  out  16  write data to memory.
REQ-008 mem_rd  out  1  and mem_wr  out  1  memory strobes.
REQ-009 mem_data_out  in  16  memory read data.
REQ-010 mem_stall  in  1  memory bank busy; the current access is not accepted.
REQ-011 err  out  1  sticky protocol/timeout error flag.

Function
REQ-012 The state machine SHALL have exactly three states: IDLE, OWN_I, OWN_D, in a 2-bit encoding.
REQ-013 IDLE transitions:
- only i_req asserted -> OWN_I.
- only d_req asserted -> OWN_D.
- both asserted -> the requester that is not last_owner.
- neither asserted -> stay in IDLE.
REQ-014 x_grant SHALL be registered: it rises in the cycle after x_req is first sampled while in IDLE (1-cycle grant latency).
REQ-015 OWN_x while x_req=1 SHALL stay in OWN_x.
REQ-016 OWN_x when x_req=0 SHALL go to OWN_other if other_req=1, otherwise to IDLE; there is no idle gap on hand-over.
REQ-017 last_owner SHALL update to x on every exit from OWN_x.
REQ-018 In OWN_x, mem_addr and mem_data_in SHALL mux from x.
REQ-019 In OWN_x, mem_rd = x_rd and mem_wr = x_wr, except that x_rd and x_wr both set -> neither is forwarded and err is set.
REQ-020 In IDLE, mem_rd = mem_wr = 0.
REQ-021 x_stall SHALL be 1 when x_req=1 and (state != OWN_x or mem_stall=1), and 0 otherwise.
REQ-022 A strobe from a non-owner SHALL be ignored.
REQ-023 Read-return tracking:
- an RD_LAT-deep shift register of {valid, owner}.
- an entry is pushed with valid=1 when mem_rd=1 and mem_stall=0.
- x_data_valid = last stage valid and owner==x.
REQ-024 Reads still in flight across an ownership hand-over SHALL be delivered to their original issuer.
REQ-025 A 5-bit hold counter SHALL clear on entry to an OWN state and increment each cycle in that state, saturating.
- counter reaching TIMEOUT-1 with the owner's req still high sets err.
- ownership is not revoked.
REQ-026 err SHALL clear only on rst.

Reset
REQ-027 On rst sampled high at a clock edge:
- state = IDLE, last_owner = I, so D wins the first conflict.
- hold counter = 0, return pipeline cleared, err = 0.
REQ-028 After reset, every output SHALL be 0 the next cycle, including x_grant, x_data_valid, mem_rd, mem_wr and x_stall, except that x_stall = x_req.
REQ-029 rst during a burst SHALL drop in-flight reads; no x_data_valid for them.

Structure
REQ-030 The state encodings and the owner encoding (I=0, D=1) SHALL be localparams at the top of the module; the codebase has no shared package.
REQ-031 All flops SHALL be instances of the existing dff cell, which is the only sub-module.

Verification
REQ-032 The bench SHALL cover the following directed scenarios:
- Solo D miss: d_req=1 with 4 writes to 0x1230..0x1236 then 4 reads to 0x4A30..0x4A36 -> d_grant in cycle 1; each read gives d_data_valid exactly 2 cycles later; i_data_valid stays 0.
- Conflict after reset: i_req and d_req rise together -> d_grant first, i_stall=1 throughout.
- Hand-over: after the D burst, d_req drops -> i_grant in the next cycle with no IDLE cycle; D's last two reads still return with d_data_valid.
- Bank stall: mem_stall=1 for 3 cycles on a read at 0x0008 -> owner stall=1 for those 3 cycles; exactly one return entry is pushed.
- Protocol and timeout errors: i_rd=i_wr=1 while owning -> mem_rd=mem_wr=0, err=1; err holds until rst. Separately, d_req held 32 cycles -> err=1 at the count of 31, d_grant is still 1.
- Mid-burst reset: rst asserted with 2 reads in flight -> no x_data_valid, state IDLE, all grants 0.
